// File: rtl/palette_port_arbiter_if.sv
// Bundle between the sprite-layer requesters, the palette ROM port and the compositor.
// PAL_BURST_LOCK_EN adds the per-requester req_lock input.
interface palette_port_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 8,
  parameter int unsigned COL_W   = 4,
  parameter int unsigned ID_W    = 2
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*IDX_W-1:0] req_index;
  logic [NUM_REQ-1:0]       req_ready;
  logic [IDX_W-1:0]         pal_index;
  logic [COL_W-1:0]         pal_red;
  logic [COL_W-1:0]         pal_green;
  logic [COL_W-1:0]         pal_blue;
  logic                     rsp_valid;
  logic [ID_W-1:0]          rsp_id;
  logic [COL_W-1:0]         rsp_red;
  logic [COL_W-1:0]         rsp_green;
  logic [COL_W-1:0]         rsp_blue;
`ifdef PAL_BURST_LOCK_EN
  logic [NUM_REQ-1:0]       req_lock;
`endif

  modport slave (
`ifdef PAL_BURST_LOCK_EN
    input  req_lock,
`endif
    input  req_valid, req_index, pal_red, pal_green, pal_blue,
    output req_ready, pal_index, rsp_valid, rsp_id, rsp_red, rsp_green, rsp_blue
  );

  modport master (
`ifdef PAL_BURST_LOCK_EN
    output req_lock,
`endif
    output req_valid, req_index, pal_red, pal_green, pal_blue,
    input  req_ready, pal_index, rsp_valid, rsp_id, rsp_red, rsp_green, rsp_blue
  );
endinterface

// File: rtl/palette_port_arbiter.sv
// Round-robin sharing of one combinational palette ROM port, 2-stage registered pipeline.
// Optional burst lock (requester keeps the port while req_lock is held) under PAL_BURST_LOCK_EN.
module palette_port_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 8,
  parameter int unsigned COL_W   = 4,
  parameter int unsigned ID_W    = 2
) (
  input logic                    Clk,
  input logic                    Reset,
  palette_port_arbiter_if.slave  bus
);

  logic [ID_W-1:0]    rr_ptr_q;
  logic               s1_valid_q;
  logic [ID_W-1:0]    s1_id_q;
  logic [IDX_W-1:0]   pal_index_q;
  logic               rsp_valid_q;
  logic [ID_W-1:0]    rsp_id_q;
  logic [COL_W-1:0]   rsp_red_q;
  logic [COL_W-1:0]   rsp_green_q;
  logic [COL_W-1:0]   rsp_blue_q;

  logic               hi_found, lo_found;
  logic [ID_W-1:0]    hi_id, lo_id;
  logic [IDX_W-1:0]   hi_idx, lo_idx;
  logic               gnt_any_d;
  logic [ID_W-1:0]    gnt_id_d;
  logic [IDX_W-1:0]   gnt_idx_d;
  logic [ID_W-1:0]    gnt_nxt_d;
  logic [NUM_REQ-1:0] ready_d;

`ifdef PAL_BURST_LOCK_EN
  typedef enum logic [0:0] {ST_IDLE, ST_LOCKED} state_t;
  state_t             state_q;
  logic [ID_W-1:0]    lock_id_q;
  logic               own_valid, own_lock, gnt_lock;
  logic [IDX_W-1:0]   own_idx;
  logic [ID_W-1:0]    own_nxt_d;
`endif

  // Search split into ids >= rr_ptr (preferred) and ids < rr_ptr, giving the circular order.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_id    = '0;
    lo_id    = '0;
    hi_idx   = '0;
    lo_idx   = '0;
`ifdef PAL_BURST_LOCK_EN
    own_valid = 1'b0;
    own_lock  = 1'b0;
    own_idx   = '0;
    gnt_lock  = 1'b0;
`endif
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (bus.req_valid[i] && !hi_found && (ID_W'(i) >= rr_ptr_q)) begin
        hi_found = 1'b1;
        hi_id    = ID_W'(i);
        hi_idx   = bus.req_index[i*IDX_W +: IDX_W];
      end
      if (bus.req_valid[i] && !lo_found && (ID_W'(i) < rr_ptr_q)) begin
        lo_found = 1'b1;
        lo_id    = ID_W'(i);
        lo_idx   = bus.req_index[i*IDX_W +: IDX_W];
      end
`ifdef PAL_BURST_LOCK_EN
      if (ID_W'(i) == lock_id_q) begin
        own_valid = bus.req_valid[i];
        own_lock  = bus.req_lock[i];
        own_idx   = bus.req_index[i*IDX_W +: IDX_W];
      end
`endif
    end
    gnt_any_d = hi_found | lo_found;
    gnt_id_d  = hi_found ? hi_id  : lo_id;
    gnt_idx_d = hi_found ? hi_idx : lo_idx;
`ifdef PAL_BURST_LOCK_EN
    if (state_q == ST_LOCKED && own_valid) begin
      gnt_any_d = 1'b1;
      gnt_id_d  = lock_id_q;
      gnt_idx_d = own_idx;
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == gnt_id_d) gnt_lock = bus.req_lock[i];
    end
    own_nxt_d = (lock_id_q == ID_W'(NUM_REQ - 1)) ? '0 : lock_id_q + ID_W'(1);
`endif
    if (Reset) gnt_any_d = 1'b0;
    gnt_nxt_d = (gnt_id_d == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id_d + ID_W'(1);
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      ready_d[i] = gnt_any_d && (gnt_id_d == ID_W'(i));
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      rr_ptr_q    <= '0;
      s1_valid_q  <= 1'b0;
      s1_id_q     <= '0;
      pal_index_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_red_q   <= '0;
      rsp_green_q <= '0;
      rsp_blue_q  <= '0;
`ifdef PAL_BURST_LOCK_EN
      state_q     <= ST_IDLE;
      lock_id_q   <= '0;
`endif
    end else begin
      // pal_index only moves on a grant so the ROM address lines stay quiet when idle.
      if (gnt_any_d) begin
        pal_index_q <= gnt_idx_d;
        s1_id_q     <= gnt_id_d;
        s1_valid_q  <= 1'b1;
      end else begin
        s1_valid_q  <= 1'b0;
      end
      rsp_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        rsp_id_q    <= s1_id_q;
        rsp_red_q   <= bus.pal_red;
        rsp_green_q <= bus.pal_green;
        rsp_blue_q  <= bus.pal_blue;
      end
`ifdef PAL_BURST_LOCK_EN
      case (state_q)
        ST_IDLE: begin
          if (gnt_any_d && gnt_lock) begin
            state_q   <= ST_LOCKED;
            lock_id_q <= gnt_id_d;
            rr_ptr_q  <= gnt_id_d;
          end else if (gnt_any_d) begin
            rr_ptr_q  <= gnt_nxt_d;
          end
        end
        ST_LOCKED: begin
          if (!(own_valid && own_lock)) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= gnt_any_d ? gnt_nxt_d : own_nxt_d;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
`else
      if (gnt_any_d) rr_ptr_q <= gnt_nxt_d;
`endif
    end
  end

  assign bus.req_ready = ready_d;
  assign bus.pal_index = pal_index_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_red   = rsp_red_q;
  assign bus.rsp_green = rsp_green_q;
  assign bus.rsp_blue  = rsp_blue_q;

endmodule

// File: tb/tb_palette_port_arbiter.sv
// Scoreboard bench for palette_port_arbiter: reference model predicts grants, a monitor checks responses.
module tb_palette_port_arbiter;
  localparam int N   = 4;
  localparam int IW  = 8;
  localparam int CW  = 4;
  localparam int IDW = 2;

  logic clk = 1'b0;
  logic Reset;
  always #5 clk = ~clk;

  palette_port_arbiter_if #(.NUM_REQ(N), .IDX_W(IW), .COL_W(CW), .ID_W(IDW)) bus();
  palette_port_arbiter #(.NUM_REQ(N), .IDX_W(IW), .COL_W(CW), .ID_W(IDW)) dut (
    .Clk(clk), .Reset(Reset), .bus(bus)
  );

  typedef struct { int id; logic [11:0] rgb; int cyc; } exp_t;
  exp_t q[$];

  int errors = 0, checks = 0, cyc = 0, rsp_count = 0, exp_rsp = 0;
  int ptr = 0;
  bit mon_en = 1'b0;
  bit rst_v = 1'b1;
  bit req_v[N];
  logic [7:0] req_i[N];
  logic [7:0] exp_pal = '0;
`ifdef PAL_BURST_LOCK_EN
  bit lock_v[N];
  int locked = -1;
`endif

  function automatic logic [11:0] rom(input logic [7:0] a);
    case (a)
      8'd0:    return 12'h000;
      8'd1:    return 12'h672;
      8'd4:    return 12'hFFF;
      8'd7:    return 12'h794;
      8'd18:   return 12'h8A5;
      default: return {a[3:0] ^ a[7:4], a[7:4] + 4'd3, ~a[3:0]};
    endcase
  endfunction

  always_comb {bus.pal_red, bus.pal_green, bus.pal_blue} = rom(bus.pal_index);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference: first valid requester in circular order starting at ptr; a lock owner wins while valid.
  function automatic int model_grant();
`ifdef PAL_BURST_LOCK_EN
    if (locked >= 0 && req_v[locked]) return locked;
`endif
    for (int k = 0; k < N; k++) begin
      int c;
      c = (ptr + k) % N;
      if (req_v[c]) return c;
    end
    return -1;
  endfunction

  function automatic void model_update(input int g);
`ifdef PAL_BURST_LOCK_EN
    if (locked < 0) begin
      if (g >= 0) begin
        if (lock_v[g]) begin locked = g; ptr = g; end
        else ptr = (g + 1) % N;
      end
    end else if (!(req_v[locked] && lock_v[locked])) begin
      ptr = (g >= 0) ? (g + 1) % N : (locked + 1) % N;
      locked = -1;
    end
`else
    if (g >= 0) ptr = (g + 1) % N;
`endif
  endfunction

  task automatic step(output int g);
    logic [3:0] exp_rdy;
    Reset = rst_v;
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i] = req_v[i];
      bus.req_index[i*IW +: IW] = req_i[i];
`ifdef PAL_BURST_LOCK_EN
      bus.req_lock[i] = lock_v[i];
`endif
    end
    #1;
    g = rst_v ? -1 : model_grant();
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
    if (g >= 0) begin
      q.push_back('{g, rom(req_i[g]), cyc});
      exp_rsp++;
    end
    @(posedge clk);
    cyc++;
    if (rst_v) begin
      ptr = 0;
`ifdef PAL_BURST_LOCK_EN
      locked = -1;
`endif
      exp_pal = '0;
      exp_rsp -= q.size();
      q.delete();
    end else begin
      model_update(g);
      if (g >= 0) exp_pal = req_i[g];
    end
    #1;
  endtask

  task automatic idle(input int n);
    int g;
    for (int i = 0; i < N; i++) req_v[i] = 1'b0;
    for (int k = 0; k < n; k++) step(g);
  endtask

  task automatic check_reset_state();
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_rsp_id", 32'(bus.rsp_id), 0);
    chk("rst_rsp_rgb", 32'({bus.rsp_red, bus.rsp_green, bus.rsp_blue}), 0);
    chk("rst_pal_index", 32'(bus.pal_index), 0);
    chk("rst_req_ready", 32'(bus.req_ready), 0);
  endtask

  // Monitor: the oldest expected response is due exactly two edges after its grant.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      chk("pal_index", 32'(bus.pal_index), 32'(exp_pal));
      if (bus.rsp_valid === 1'b1) rsp_count++;
      if (q.size() > 0 && q[0].cyc + 2 <= cyc) begin
        e = q.pop_front();
        chk("rsp_valid_due", 32'(bus.rsp_valid), 1);
        if (bus.rsp_valid === 1'b1) begin
          chk("rsp_id", 32'(bus.rsp_id), 32'(e.id));
          chk("rsp_rgb", 32'({bus.rsp_red, bus.rsp_green, bus.rsp_blue}), 32'(e.rgb));
        end
      end else begin
        chk("rsp_valid_idle", 32'(bus.rsp_valid), 0);
      end
    end
  end

  initial begin
    int g, c0;
    for (int i = 0; i < N; i++) begin
      req_v[i] = 1'b0; req_i[i] = '0;
`ifdef PAL_BURST_LOCK_EN
      lock_v[i] = 1'b0;
`endif
    end
    // Reset with a pending request: no grant, outputs cleared.
    rst_v = 1'b1;
    req_v[0] = 1'b1; req_i[0] = 8'd4;
    step(g);
    mon_en = 1'b1;
    check_reset_state();
    step(g);
    check_reset_state();
    rst_v = 1'b0;
    step(g);
    idle(3);
    // Move ptr back to 0, then all four continuously valid.
    req_v[3] = 1'b1; req_i[3] = 8'd0;
    step(g);
    req_i[0] = 8'd1; req_i[1] = 8'd7; req_i[2] = 8'd18; req_i[3] = 8'd0;
    for (int i = 0; i < N; i++) req_v[i] = 1'b1;
    for (int k = 0; k < 8; k++) step(g);
    idle(2);
    // ptr to 2 via requester 1, then 1 and 3 alternate across the wrap.
    req_v[1] = 1'b1; req_i[1] = 8'd33;
    step(g);
    req_v[3] = 1'b1; req_i[3] = 8'd77;
    for (int k = 0; k < 3; k++) step(g);
    idle(2);
    // 16-cycle single-requester burst: 16 back-to-back pulses, pal_index then holds.
    c0 = rsp_count;
    req_v[2] = 1'b1;
    for (int k = 0; k < 16; k++) begin
      req_i[2] = 8'(16 + k * 5);
      step(g);
    end
    idle(4);
    chk("burst_pulses", 32'(rsp_count - c0), 16);
    // Reset one cycle after a grant drops the lookup.
    req_v[1] = 1'b1; req_i[1] = 8'd9;
    step(g);
    req_v[1] = 1'b0;
    rst_v = 1'b1;
    step(g);
    check_reset_state();
    rst_v = 1'b0;
    idle(4);
    // Lock scenario: ptr to 2, requester 2 locked while all are valid.
    req_v[1] = 1'b1; req_i[1] = 8'd3;
    step(g);
    for (int i = 0; i < N; i++) begin req_v[i] = 1'b1; req_i[i] = 8'(40 + i); end
`ifdef PAL_BURST_LOCK_EN
    lock_v[2] = 1'b1;
`endif
    for (int k = 0; k < 4; k++) step(g);
`ifdef PAL_BURST_LOCK_EN
    lock_v[2] = 1'b0;
`endif
    for (int k = 0; k < 5; k++) step(g);
    idle(3);
    // Randomized traffic with withdrawals.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_v[i]) begin
          if ($urandom_range(0, 2) == 0) begin req_v[i] = 1'b1; req_i[i] = 8'($urandom); end
        end else if ($urandom_range(0, 19) == 0) begin
          req_v[i] = 1'b0;
        end
`ifdef PAL_BURST_LOCK_EN
        lock_v[i] = ($urandom_range(0, 3) == 0);
`endif
      end
      step(g);
      if (g >= 0) begin
        req_v[g] = ($urandom_range(0, 1) == 1);
        req_i[g] = 8'($urandom);
      end
    end
    idle(4);
    chk("rsp_total", 32'(rsp_count), 32'(exp_rsp));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/palette_port_arbiter.md
Name: palette_port_arbiter

Overview:
- Shares one combinational palette ROM port (e.g. turret5_palette: 8-bit index -> 4/4/4 RGB) among NUM_REQ sprite-layer requesters (tank body, turret, bullet, HUD).
- Uses round-robin arbitration and a 2-stage registered pipeline, issuing one lookup per cycle.
- Sits between the sprite fetch units and the palette ROM, in front of the pixel compositor.

Parameters:
- NUM_REQ, 4, number of requesters; range 2..8.
- IDX_W, 8, palette index width.
- COL_W, 4, width of each colour channel.
- ID_W, 2, requester-id width; must satisfy ID_W >= clog2(NUM_REQ).

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester lookup request.
- req_index  in  NUM_REQ*IDX_W  packed indices; requester i uses bits [i*IDX_W +: IDX_W].
- req_ready  out  NUM_REQ  one-hot grant, combinational; a transfer occurs when req_valid[i] & req_ready[i].
- pal_index  out  IDX_W  registered index driven to the palette ROM.
- pal_red, pal_green, pal_blue  in  COL_W each  combinational ROM output for pal_index.
- rsp_valid  out  1  response strobe, one cycle per accepted request.
- rsp_id  out  ID_W  requester that owns the response.
- rsp_red, rsp_green, rsp_blue  out  COL_W each  looked-up colour.
- req_lock  in  NUM_REQ  present only with PAL_BURST_LOCK_EN.

Behaviour:
- Reset values (applied on the Clk edge where Reset=1):
  - rr_ptr=0, s1_valid=0, s1_id=0, pal_index=0.
  - rsp_valid=0, rsp_id=0, rsp_red/green/blue=0.
- A reset mid-operation drops all in-flight lookups with no response issued.
- req_ready is combinational from req_valid and rr_ptr.
  - It is forced to all-zero while Reset=1.
  - At most one bit is set.
- Grant rule: the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - If no request is valid, there is no grant and rr_ptr holds.
- On a grant to g: rr_ptr <= (g+1) mod NUM_REQ. The wrap from NUM_REQ-1 goes to 0.
- Requester protocol: req_valid and req_index must stay stable until accepted. Dropping req_valid before grant is allowed and withdraws the request.
- Pipeline, for a request accepted at edge k:
  - Stage 1 at edge k: pal_index <= req_index[g], s1_id <= g, s1_valid <= 1.
  - With no grant at edge k: s1_valid <= 0 and pal_index holds its last value (no toggling, for power).
  - Stage 2 at edge k+1: rsp_valid <= s1_valid, rsp_id <= s1_id, rsp_rgb <= pal_rgb.
  - When s1_valid=0: rsp_valid <= 0 and rsp data holds.
- Latency: rsp_valid is high in the cycle after edge k+1, i.e. 2 cycles after acceptance.
- Throughput: 1 lookup per cycle, with no bubbles under continuous requests.
- Responses have no backpressure: consumers must capture them on rsp_valid.
- Responses are returned in acceptance order; rsp_id disambiguates the owner.
- Index 0 (transparent) is looked up like any other index; the compositor interprets it.
- Simultaneous events:
  - A new grant and a response retiring on the same edge are independent, and both occur.
  - Only one requester is granted per cycle; all others see req_ready=0 and wait.
- Fairness: with all requesters continuously valid, each is granted exactly once every NUM_REQ cycles.

Optional Feature:
- Macro: PAL_BURST_LOCK_EN.
- Defined:
  - req_lock port exists and a LOCKED state is added: IDLE -> LOCKED when granted requester g has req_lock[g]=1.
  - While in LOCKED, g wins whenever req_valid[g]=1, and rr_ptr is frozen at g.
  - LOCKED -> IDLE on the first cycle with req_lock[g]=0 or req_valid[g]=0; rr_ptr <= g+1 at that point.
  - Purpose: lets a sprite row fetch stream contiguous pixels.
  - Reset returns the FSM to IDLE.
- Undefined: the port is absent, the arbiter is pure round-robin, and there is no LOCKED state.

Test Plan:
1. Reset, then requester 0 valid with index 4 -> req_ready=0001 the same cycle; rsp_valid=1 two cycles later with rsp_id=0 and RGB=F,F,F. All outputs are 0 during reset.
2. All 4 requesters valid continuously with indices 1, 7, 18, 0 -> grants 0,1,2,3,0,... one per cycle. Responses are in order: (6,7,2), (7,9,4), (8,A,5), (0,0,0), with rsp_id 0,1,2,3.
3. Requesters 1 and 3 valid after rr_ptr=2 -> grant goes to 3, then 1, then 3. rr_ptr wraps 3->0 correctly.
4. Continuous single requester for 16 cycles, then idle -> exactly 16 rsp_valid pulses and no gap. pal_index holds its final value after going idle.
5. Reset asserted one cycle after a grant -> no rsp_valid is ever produced for that request, and all state is 0 on the next cycle.
6. PAL_BURST_LOCK_EN: requester 2 locks for 5 cycles while 0, 1 and 3 are valid -> 5 consecutive grants to 2, then grants 3, 0, 1. Without the macro, the same stimulus gives a grant rotation of 2,3,0,1.
